// File: rtl/vint_arbiter.sv
// Vectored-interrupt arbiter: fixed-priority selection of pending level
// requests and the istb/iack/ivec vector-fetch handshake toward the CPU.
module vint_arbiter #(
   parameter int unsigned N_SRC    = 8,
   parameter logic [15:0] SPUR_VEC = 16'o000000
) (
   input  logic                   clk_p,
   input  logic                   rst_n,
   input  logic                   init,
   input  logic [N_SRC-1:0]       irq_req,
   input  logic [N_SRC-1:0]       irq_mask,
   input  logic [16*N_SRC-1:0]    irq_vec,
   output logic [N_SRC-1:0]       irq_ack,
   output logic                   virq,
   input  logic                   istb,
   output logic                   iack,
   output logic [15:0]            ivec
);

   localparam int unsigned VEC_W      = 16;
   localparam logic [VEC_W-1:0] ALIGN = 16'hFFFC;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state;
   logic [N_SRC-1:0]   pend;
   logic [N_SRC-1:0]   win_oh;
   logic               win_any;
   logic [VEC_W-1:0]   win_vec;

   // Enabled requests only take part in arbitration.
   always_comb begin
      pend = irq_req & irq_mask;
   end

   // Lowest-index pending source wins; one-hot grant plus its vector.
   always_comb begin
      win_oh  = '0;
      win_any = 1'b0;
      win_vec = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (pend[i] && !win_any) begin
            win_any   = 1'b1;
            win_oh[i] = 1'b1;
            win_vec   = irq_vec[VEC_W*i +: VEC_W];
         end
      end
   end

   // Handshake FSM with registered outputs; init acts as a synchronous reset.
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         virq    <= 1'b0;
         iack    <= 1'b0;
         ivec    <= '0;
         irq_ack <= '0;
      end else if (init) begin
         state   <= IDLE;
         virq    <= 1'b0;
         iack    <= 1'b0;
         ivec    <= '0;
         irq_ack <= '0;
      end else begin
         irq_ack <= '0;
         case (state)
            IDLE: begin
               if (istb) begin
                  iack    <= 1'b1;
                  virq    <= 1'b0;
                  irq_ack <= win_oh;
                  ivec    <= (win_any ? win_vec : SPUR_VEC) & ALIGN;
                  state   <= ACK;
               end else begin
                  virq <= |pend;
               end
            end
            ACK: begin
               virq <= 1'b0;
               if (!istb) begin
                  iack  <= 1'b0;
                  ivec  <= '0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               // Dead cycle so the served device can drop its request.
               virq  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               virq  <= 1'b0;
               iack  <= 1'b0;
               ivec  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vint_arbiter.sv
// Scoreboard bench for vint_arbiter: stimulus pushes expected fetch results,
// a monitor pops and compares on each rising iack.
module tb_vint_arbiter;

   localparam int unsigned N       = 8;
   localparam logic [15:0] SPUR    = 16'o000774;

   logic            clk_p = 1'b0;
   logic            rst_n;
   logic            init;
   logic [N-1:0]    irq_req;
   logic [N-1:0]    irq_mask;
   logic [16*N-1:0] irq_vec;
   logic [N-1:0]    irq_ack;
   logic            virq;
   logic            istb;
   logic            iack;
   logic [15:0]     ivec;

   logic [15:0]     vecs [N];

   typedef struct {
      logic [15:0]  v;
      logic [N-1:0] oh;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   vint_arbiter #(.N_SRC(N), .SPUR_VEC(SPUR)) dut (
      .clk_p    (clk_p),
      .rst_n    (rst_n),
      .init     (init),
      .irq_req  (irq_req),
      .irq_mask (irq_mask),
      .irq_vec  (irq_vec),
      .irq_ack  (irq_ack),
      .virq     (virq),
      .istb     (istb),
      .iack     (iack),
      .ivec     (ivec)
   );

   always #5 clk_p = ~clk_p;

   always_comb begin
      for (int i = 0; i < int'(N); i++) irq_vec[16*i +: 16] = vecs[i];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: lowest set bit of the enabled requests selects the vector.
   function automatic void model(input logic [N-1:0] req, input logic [N-1:0] mask,
                                 output logic [15:0] v, output logic [N-1:0] oh);
      logic [N-1:0] p;
      int           idx;
      p   = req & mask;
      oh  = p & (~p + N'(1));
      idx = 0;
      for (int k = 0; k < int'(N); k++) if (oh[k]) idx = k;
      if (p == '0) v = SPUR & 16'hFFFC;
      else         v = vecs[idx] & 16'hFFFC;
   endfunction

   // Monitor: every rising iack must match the oldest expected fetch.
   initial begin
      logic        iack_q;
      logic [15:0] ivec_q;
      exp_t        e;
      iack_q = 1'b0;
      ivec_q = '0;
      forever begin
         @(negedge clk_p);
         if (iack === 1'b1 && iack_q !== 1'b1) begin
            if (q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_iack: got ivec %h expected no fetch", ivec);
            end else begin
               e = q.pop_front();
               check("ivec", 32'(ivec), 32'(e.v));
               check("irq_ack_pulse", 32'(irq_ack), 32'(e.oh));
            end
         end else begin
            check("irq_ack_quiet", 32'(irq_ack), 32'd0);
         end
         if (iack === 1'b1 && iack_q === 1'b1)
            check("ivec_stable", 32'(ivec), 32'(ivec_q));
         iack_q = iack;
         ivec_q = ivec;
      end
   end

   // One complete fetch: push expectation, strobe, hold, release.
   task automatic do_fetch(input int hold, input bit drop);
      exp_t e;
      model(irq_req, irq_mask, e.v, e.oh);
      q.push_back(e);
      istb = 1'b1;
      @(negedge clk_p);
      check("fetch_latency", 32'(iack), 32'd1);
      check("virq_in_ack", 32'(virq), 32'd0);
      for (int k = 0; k < hold; k++) begin
         if ($urandom_range(0, 1) == 1) irq_req = N'($urandom);
         @(negedge clk_p);
         check("iack_hold", 32'(iack), 32'd1);
      end
      istb = 1'b0;
      if (drop) irq_req = irq_req & ~e.oh;
      @(negedge clk_p);
      check("iack_drop", 32'(iack), 32'd0);
      check("ivec_clear", 32'(ivec), 32'd0);
      check("virq_release", 32'(virq), 32'd0);
      @(negedge clk_p);
      check("virq_dead", 32'(virq), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b0;
      init     = 1'b0;
      istb     = 1'b0;
      irq_req  = 8'hFF;
      irq_mask = 8'hFF;
      for (int i = 0; i < int'(N); i++) vecs[i] = 16'(16'o000100 + 4 * i);

      // Reset holds all outputs low even with every request active.
      repeat (3) @(negedge clk_p);
      check("rst_virq", 32'(virq), 32'd0);
      check("rst_iack", 32'(iack), 32'd0);
      check("rst_ivec", 32'(ivec), 32'd0);
      check("rst_ack",  32'(irq_ack), 32'd0);
      rst_n = 1'b1;
      @(negedge clk_p);
      check("virq_after_rst", 32'(virq), 32'd1);

      // Asynchronous assertion clears outputs without a clock edge.
      #2 rst_n = 1'b0;
      #1 check("async_rst_virq", 32'(virq), 32'd0);
      @(negedge clk_p);
      rst_n = 1'b1;

      // Single source.
      irq_req = 8'b0000_0100;
      vecs[2] = 16'o000060;
      @(negedge clk_p);
      check("single_virq", 32'(virq), 32'd1);
      do_fetch(1, 1'b1);

      // Priority chain: sources 1, 4, 7 served in order.
      irq_req = 8'b1001_0010;
      vecs[1] = 16'o000064;
      vecs[4] = 16'o000300;
      vecs[7] = 16'o000360;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk_p);
         check("prio_virq", 32'(virq), 32'd1);
         do_fetch(0, 1'b1);
      end
      @(negedge clk_p);
      check("prio_idle_virq", 32'(virq), 32'd0);

      // Masked source 0 is never served.
      irq_req  = 8'b0000_0011;
      irq_mask = 8'b1111_1110;
      @(negedge clk_p);
      check("mask_virq", 32'(virq), 32'd1);
      do_fetch(0, 1'b1);
      irq_mask = 8'h00;
      irq_req  = 8'hFF;
      repeat (2) begin
         @(negedge clk_p);
         check("mask_all_virq", 32'(virq), 32'd0);
      end
      irq_mask = 8'hFF;

      // Withdrawn request yields the spurious vector.
      irq_req = 8'b0000_1000;
      @(negedge clk_p);
      check("spur_virq", 32'(virq), 32'd1);
      irq_req = 8'h00;
      @(negedge clk_p);
      do_fetch(0, 1'b0);

      // Init mid-handshake aborts the fetch.
      irq_req = 8'b0000_1000;
      vecs[3] = 16'o000100;
      @(negedge clk_p);
      begin
         exp_t e;
         model(irq_req, irq_mask, e.v, e.oh);
         q.push_back(e);
      end
      istb = 1'b1;
      @(negedge clk_p);
      check("init_pre_iack", 32'(iack), 32'd1);
      @(negedge clk_p);
      init = 1'b1;
      @(negedge clk_p);
      check("init_iack", 32'(iack), 32'd0);
      check("init_ivec", 32'(ivec), 32'd0);
      check("init_virq", 32'(virq), 32'd0);
      init = 1'b0;
      istb = 1'b0;
      @(negedge clk_p);
      check("post_init_virq", 32'(virq), 32'd1);
      do_fetch(0, 1'b1);

      // Randomized traffic.
      for (int it = 0; it < 60; it++) begin
         irq_req  = N'($urandom);
         irq_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
         for (int i = 0; i < int'(N); i++) vecs[i] = 16'($urandom);
         @(negedge clk_p);
         check("rand_virq", 32'(virq), 32'(|(irq_req & irq_mask)));
         if ($urandom_range(0, 3) == 0) begin
            irq_req = irq_req & (irq_req - N'(1));
            @(negedge clk_p);
         end
         do_fetch(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk_p);
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
